// File: rtl/pipelined_control_unit.sv
// ID-stage decode and ID/EX control register for the 5-stage MIPS pipeline,
// with a destination history that drives load-use stalls and JR forwarding.
module pipelined_control_unit #(
  parameter int ALUOP_W   = 4,
  parameter int FWD_DEPTH = 2,
  parameter int RA_W      = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [RA_W-1:0]    rs,
  input  logic [RA_W-1:0]    rt,
  input  logic [RA_W-1:0]    rd,
  input  logic               flush,
  output logic               stall,
  output logic [2:0]         jr_fwd_sel,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [1:0]         ex_jump,
  output logic [RA_W-1:0]    ex_dest,
  output logic               illegal
);

  logic       legal, is_jr, rs_used, rt_used;
  logic       d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write;
  logic       d_branch, d_reg_dst, d_alu_src;
  logic [3:0] d_alu_op;

  always_comb begin
    legal = 1'b0; is_jr = 1'b0; rs_used = 1'b0; rt_used = 1'b0;
    d_reg_write = 1'b0; d_mem_to_reg = 1'b0; d_mem_read = 1'b0;
    d_mem_write = 1'b0; d_branch = 1'b0; d_reg_dst = 1'b0;
    d_alu_src = 1'b0; d_alu_op = 4'b0000;
    case (opcode)
      6'b000000: begin
        legal = 1'b1; d_reg_write = 1'b1; rs_used = 1'b1; rt_used = 1'b1;
        case (funct)
          6'b100000: d_alu_op = 4'b0001;
          6'b100001: d_alu_op = 4'b1010;
          6'b100010: d_alu_op = 4'b0010;
          6'b100011: d_alu_op = 4'b1011;
          6'b100100: d_alu_op = 4'b0011;
          6'b100101: d_alu_op = 4'b0100;
          6'b100111: d_alu_op = 4'b0101;
          6'b101010: d_alu_op = 4'b0110;
          6'b000000: begin d_alu_op = 4'b0111; rs_used = 1'b0; end
          6'b000010: begin d_alu_op = 4'b1000; rs_used = 1'b0; end
          6'b000011: begin d_alu_op = 4'b1001; rs_used = 1'b0; end
          6'b001000: begin is_jr = 1'b1; d_reg_write = 1'b0; rt_used = 1'b0; end
          default: begin
            legal = 1'b0; d_reg_write = 1'b0; rs_used = 1'b0; rt_used = 1'b0;
          end
        endcase
      end
      6'b001100: begin legal = 1'b1; d_alu_op = 4'b0011; end
      6'b001101: begin legal = 1'b1; d_alu_op = 4'b0100; end
      6'b001010: begin legal = 1'b1; d_alu_op = 4'b0110; end
      6'b001000: begin legal = 1'b1; d_alu_op = 4'b0001; end
      6'b001001: begin legal = 1'b1; d_alu_op = 4'b1010; end
      6'b001111: begin legal = 1'b1; d_alu_op = 4'b1111; end
      6'b000100: begin legal = 1'b1; d_branch = 1'b1; d_alu_op = 4'b0010; rt_used = 1'b1; end
      6'b000101: begin legal = 1'b1; d_branch = 1'b1; d_alu_op = 4'b1110; rt_used = 1'b1; end
      6'b000111: begin legal = 1'b1; d_branch = 1'b1; d_alu_op = 4'b1100; end
      6'b000001: begin legal = 1'b1; d_branch = 1'b1; d_alu_op = 4'b1101; end
      6'b100011: begin
        legal = 1'b1; d_alu_op = 4'b0001; d_mem_read = 1'b1; d_mem_to_reg = 1'b1;
      end
      6'b101011: begin
        legal = 1'b1; d_alu_op = 4'b0001; d_alu_src = 1'b1; d_mem_write = 1'b1; rt_used = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // I-type ALU ops and lw share ALUSrc/RegWrite/RegDst and all use rs.
    if (legal && opcode != 6'b000000 && !d_branch && !d_mem_write) begin
      d_alu_src = 1'b1; d_reg_write = 1'b1; d_reg_dst = 1'b1;
    end
    if (legal && opcode != 6'b000000) rs_used = 1'b1;
  end

  logic [RA_W-1:0] d_dest;
  logic            rw_eff, load_use, issue;
  logic [FWD_DEPTH-1:0] h_valid, h_load;
  logic [RA_W-1:0]      h_dest [FWD_DEPTH];

  assign d_dest   = d_reg_dst ? rt : rd;
  assign rw_eff   = d_reg_write && (d_dest != '0);
  assign load_use = instr_valid && legal && h_valid[0] && h_load[0] &&
                    ((rs_used && rs != '0 && rs == h_dest[0]) ||
                     (rt_used && rt != '0 && rt == h_dest[0]));
  assign stall    = reset_n && !flush && load_use;
  assign issue    = instr_valid && legal && !flush && !load_use;

  // Descending scan so the nearest matching stage wins.
  always_comb begin
    jr_fwd_sel = 3'd0;
    if (reset_n && instr_valid && is_jr && rs != '0 && !load_use) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (h_valid[k] && h_dest[k] == rs) jr_fwd_sel = 3'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_reg_write <= 1'b0; ex_mem_to_reg <= 1'b0; ex_mem_read <= 1'b0;
      ex_mem_write <= 1'b0; ex_branch <= 1'b0; ex_reg_dst <= 1'b0;
      ex_alu_src <= 1'b0; ex_alu_op <= '0; ex_jump <= 2'b00; ex_dest <= '0;
      illegal <= 1'b0;
      h_valid <= '0; h_load <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) h_dest[k] <= '0;
    end else begin
      ex_reg_write  <= issue && rw_eff;
      ex_mem_to_reg <= issue && d_mem_to_reg;
      ex_mem_read   <= issue && d_mem_read;
      ex_mem_write  <= issue && d_mem_write;
      ex_branch     <= issue && d_branch;
      ex_reg_dst    <= issue && d_reg_dst;
      ex_alu_src    <= issue && d_alu_src;
      ex_alu_op     <= issue ? ALUOP_W'(d_alu_op) : '0;
      ex_jump       <= (issue && is_jr) ? 2'b01 : 2'b00;
      ex_dest       <= issue ? d_dest : '0;
      illegal       <= instr_valid && !flush && !legal;
      h_valid[0]    <= issue && rw_eff;
      h_load[0]     <= issue && d_mem_read;
      h_dest[0]     <= issue ? d_dest : '0;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        h_valid[k] <= h_valid[k-1];
        h_load[k]  <= h_load[k-1];
        h_dest[k]  <= h_dest[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: two instances (forwarding depth 2 and 3) share the same
// instruction stream; expected values are hand-computed per vector.
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       instr_valid = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       flush = 1'b0;

  logic       stall2, stall3, illegal2, illegal3;
  logic [2:0] sel2, sel3;
  logic       rw2, mtr2, mr2, mw2, br2, rdst2, asrc2;
  logic       rw3, mtr3, mr3, mw3, br3, rdst3, asrc3;
  logic [3:0] aop2, aop3;
  logic [1:0] jmp2, jmp3;
  logic [4:0] dst2, dst3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.ALUOP_W(4), .FWD_DEPTH(2), .RA_W(5)) u2 (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .flush(flush), .stall(stall2),
    .jr_fwd_sel(sel2), .ex_reg_write(rw2), .ex_mem_to_reg(mtr2), .ex_mem_read(mr2),
    .ex_mem_write(mw2), .ex_branch(br2), .ex_reg_dst(rdst2), .ex_alu_src(asrc2),
    .ex_alu_op(aop2), .ex_jump(jmp2), .ex_dest(dst2), .illegal(illegal2));

  pipelined_control_unit #(.ALUOP_W(4), .FWD_DEPTH(3), .RA_W(5)) u3 (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .flush(flush), .stall(stall3),
    .jr_fwd_sel(sel3), .ex_reg_write(rw3), .ex_mem_to_reg(mtr3), .ex_mem_read(mr3),
    .ex_mem_write(mw3), .ex_branch(br3), .ex_reg_dst(rdst3), .ex_alu_src(asrc3),
    .ex_alu_op(aop3), .ex_jump(jmp3), .ex_dest(dst3), .illegal(illegal3));

  // {reg_write, mem_to_reg, mem_read, mem_write, branch, reg_dst, alu_src, alu_op, jump, dest}
  logic [17:0] ex2, ex3;
  assign ex2 = {rw2, mtr2, mr2, mw2, br2, rdst2, asrc2, aop2, jmp2, dst2};
  assign ex3 = {rw3, mtr3, mr3, mw3, br3, rdst3, asrc3, aop3, jmp3, dst3};

  function automatic logic [17:0] bundle(input logic [6:0] flags, input logic [3:0] aop,
                                         input logic [1:0] jmp, input logic [4:0] dst);
    return {flags, aop, jmp, dst};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    instr_valid = v; opcode = op; funct = fn; rs = s; rt = t; rd = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_BGEZ = 6'b000001;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SLL = 6'b000000, F_JR = 6'b001000;
  localparam logic [5:0] F_SRA = 6'b000011;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    check("rst_ex", ex2, 18'h0);
    check("rst_illegal", illegal2, 0);
    check("rst_stall", stall2, 0);
    check("rst_sel", sel2, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // add $3,$1,$2 then lw $8,0($4)
    set_in(1, OP_R, F_ADD, 1, 2, 3);
    tick();
    check("add_ex", ex2, bundle(7'b1000000, 4'b0001, 2'b00, 5'd3));
    set_in(1, OP_LW, 6'd0, 4, 8, 0);
    check("lw_nostall", stall2, 0);
    tick();
    check("lw_ex", ex2, bundle(7'b1110011, 4'b0001, 2'b00, 5'd8));

    // load-use: add $9,$8,$3
    set_in(1, OP_R, F_ADD, 8, 3, 9);
    check("lu_stall", stall2, 1);
    tick();
    check("lu_bubble", ex2, 18'h0);
    check("lu_stall_gone", stall2, 0);
    tick();
    check("lu_add_ex", ex2, bundle(7'b1000000, 4'b0001, 2'b00, 5'd9));

    // lw $0 writes nothing; add $9,$0,$3 must not stall
    set_in(1, OP_LW, 6'd0, 4, 0, 0);
    tick();
    check("lw0_ex", ex2, bundle(7'b0110011, 4'b0001, 2'b00, 5'd0));
    set_in(1, OP_R, F_ADD, 0, 3, 9);
    check("lw0_nostall", stall2, 0);
    tick();

    // sll reads rt only: lw $8 then sll $9,$0 with rs field = 8
    set_in(1, OP_LW, 6'd0, 4, 8, 0);
    tick();
    set_in(1, OP_R, F_SLL, 8, 0, 9);
    check("sll_rs_unused", stall2, 0);
    tick();
    check("sll_ex", ex2, bundle(7'b1000000, 4'b0111, 2'b00, 5'd9));

    // Assorted decode vectors
    set_in(1, OP_BEQ, 6'd0, 1, 2, 0);
    tick();
    check("beq_ex", ex2, bundle(7'b0000100, 4'b0010, 2'b00, 5'd0));
    set_in(1, OP_BGEZ, 6'd0, 1, 1, 7);
    tick();
    check("bgez_ex", ex2, bundle(7'b0000100, 4'b1101, 2'b00, 5'd7));
    set_in(1, OP_ORI, 6'd0, 1, 6, 0);
    tick();
    check("ori_ex", ex2, bundle(7'b1000011, 4'b0100, 2'b00, 5'd6));
    set_in(1, OP_SW, 6'd0, 1, 6, 0);
    tick();
    check("sw_ex", ex2, bundle(7'b0001001, 4'b0001, 2'b00, 5'd0));
    set_in(1, OP_R, F_SRA, 0, 2, 5);
    tick();
    check("sra_ex", ex2, bundle(7'b1000000, 4'b1001, 2'b00, 5'd5));

    // JR forwarding, distance 1
    set_in(1, OP_ADDI, 6'd0, 0, 31, 0);
    tick();
    set_in(1, OP_R, F_JR, 31, 0, 0);
    check("jr1_sel2", sel2, 1);
    check("jr1_sel3", sel3, 1);
    check("jr1_stall", stall2, 0);
    tick();
    check("jr_ex", ex2, bundle(7'b0000000, 4'b0000, 2'b01, 5'd0));

    // distance 2
    set_in(1, OP_ADDI, 6'd0, 0, 31, 0);
    tick();
    set_in(1, OP_R, F_SLL, 0, 0, 0);
    tick();
    check("nop_ex", ex2, bundle(7'b0000000, 4'b0111, 2'b00, 5'd0));
    set_in(1, OP_R, F_JR, 31, 0, 0);
    check("jr2_sel2", sel2, 2);
    check("jr2_sel3", sel3, 2);
    tick();

    // distance 3: beyond depth 2, within depth 3
    set_in(1, OP_ADDI, 6'd0, 0, 31, 0);
    tick();
    set_in(1, OP_R, F_SLL, 0, 0, 0);
    tick();
    tick();
    set_in(1, OP_R, F_JR, 31, 0, 0);
    check("jr3_sel2", sel2, 0);
    check("jr3_sel3", sel3, 3);
    tick();

    // lw $31 then jr $31: one stall, then forward from stage 2
    set_in(1, OP_LW, 6'd0, 0, 31, 0);
    tick();
    set_in(1, OP_R, F_JR, 31, 0, 0);
    check("jrlw_stall", stall2, 1);
    check("jrlw_sel", sel2, 0);
    tick();
    check("jrlw_bubble", ex2, 18'h0);
    check("jrlw_stall_gone", stall2, 0);
    check("jrlw_sel_after", sel2, 2);
    tick();

    // flush during a load-use condition
    set_in(1, OP_LW, 6'd0, 4, 8, 0);
    tick();
    flush = 1'b1;
    set_in(1, OP_SW, 6'd0, 8, 8, 0);
    check("flush_stall", stall2, 0);
    tick();
    check("flush_ex", ex2, 18'h0);
    set_in(1, OP_BAD, 6'd0, 0, 0, 0);
    tick();
    check("flush_no_illegal", illegal2, 0);
    flush = 1'b0;

    // illegal opcode / funct
    set_in(1, OP_BAD, 6'd0, 1, 2, 3);
    tick();
    check("ill_ex", ex2, 18'h0);
    check("ill_pulse", illegal2, 1);
    set_in(1, OP_R, F_SLL, 0, 0, 0);
    tick();
    check("ill_clear", illegal2, 0);
    set_in(0, OP_BAD, 6'd0, 1, 2, 3);
    tick();
    check("ill_invalid", illegal2, 0);
    check("invalid_ex", ex2, 18'h0);
    set_in(1, OP_R, 6'b111111, 1, 2, 3);
    tick();
    check("ill_funct", illegal2, 1);

    // asynchronous reset mid-stall
    set_in(1, OP_LW, 6'd0, 4, 8, 0);
    tick();
    set_in(1, OP_R, F_ADD, 8, 3, 9);
    check("rst_pre_stall", stall2, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_stall", stall2, 0);
    check("rst_mid_ex", ex2, 18'h0);
    check("rst_mid_ex3", ex3, 18'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    check("rst_post_stall", stall2, 0);
    tick();
    check("rst_post_ex", ex2, bundle(7'b1000000, 4'b0001, 2'b00, 5'd9));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
